// File: rtl/counts_readout_if.sv
// Byte stream toward the host link: one byte per transfer, valid/ready handshake.
interface counts_readout_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/counts_readout.sv
// Snapshots the pair-coincidence counts on a trigger and streams them as a framed,
// XOR-checksummed byte sequence: A5, seq, one byte per pair, checksum.
//
// state | meaning
// IDLE  | no frame in flight, waiting for start, timer expiry or pending request
// HDR   | presenting header byte 0xA5
// SEQ   | presenting frame sequence number
// DATA  | presenting snapshot counts, pair 0 first
// CSUM  | presenting XOR of all preceding frame bytes
module counts_readout #(
  parameter  int NCHAN  = 6,
  parameter  int NBITS  = 4,
  parameter  int PERIOD = 0,
  localparam int NPAIRS = NCHAN * (NCHAN - 1) / 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NPAIRS-1:0][NBITS-1:0]   counts,
  input  logic                           start,
  output logic                           snap_clear,
  output logic                           busy,
  counts_readout_if.master               tx
);

  typedef enum logic [2:0] {IDLE, HDR, SEQ, DATA, CSUM} state_t;

  localparam logic [7:0] HEADER = 8'hA5;
  localparam int         RW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

  state_t                       state;
  logic [7:0]                   seq;
  logic [7:0]                   checksum;
  logic [7:0]                   tx_data_q;
  logic                         tx_valid_q;
  logic                         pending;
  logic [NPAIRS-1:0][NBITS-1:0] snap;
  logic [RW-1:0]                remain;
  logic                         expire;
  logic                         req;
  logic                         xfer;
  logic                         launch;

  if (PERIOD > 0) begin : g_timer
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    logic [TW-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        timer <= '0;
      end else if (timer == TW'(PERIOD - 1)) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end

    assign expire = (timer == TW'(PERIOD - 1));
  end else begin : g_no_timer
    assign expire = 1'b0;
  end

  assign req  = start | expire;
  assign xfer = tx_valid_q & tx.tx_ready;

  // A new frame starts from IDLE, or directly off an accepted checksum when a request is queued.
  assign launch = ((state == IDLE) && (req || pending)) ||
                  ((state == CSUM) && xfer && pending);

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      seq        <= '0;
      checksum   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      pending    <= 1'b0;
      snap       <= '0;
      remain     <= '0;
      snap_clear <= 1'b0;
    end else begin
      snap_clear <= 1'b0;

      case (state)
        HDR: begin
          if (xfer) begin
            checksum  <= checksum ^ tx_data_q;
            tx_data_q <= seq;
            state     <= SEQ;
          end
        end
        SEQ: begin
          if (xfer) begin
            checksum  <= checksum ^ tx_data_q;
            tx_data_q <= 8'(snap[0]);
            snap      <= snap >> NBITS;
            remain    <= RW'(NPAIRS - 1);
            state     <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            checksum <= checksum ^ tx_data_q;
            if (remain == '0) begin
              tx_data_q <= checksum ^ tx_data_q;
              state     <= CSUM;
            end else begin
              tx_data_q <= 8'(snap[0]);
              snap      <= snap >> NBITS;
              remain    <= remain - 1'b1;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            seq        <= seq + 8'd1;
            state      <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
          end
        end
        default: ;
      endcase

      if (launch) begin
        snap       <= counts;
        snap_clear <= 1'b1;
        checksum   <= '0;
        tx_data_q  <= HEADER;
        tx_valid_q <= 1'b1;
        state      <= HDR;
      end

      // One queued request at most; a launch from CSUM frees the slot for a request on that edge.
      if (state == IDLE) begin
        pending <= 1'b0;
      end else if ((state == CSUM) && xfer && pending) begin
        pending <= req;
      end else if (req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counts_readout.sv
// Directed bench for counts_readout: frame content, stalls, snapshot isolation,
// queued triggers, async reset abort and the period timer.
module tb_counts_readout;
  localparam int NP = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0][3:0] counts0, counts1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic snap0, snap1, busy0, busy1;

  counts_readout_if tx0 ();
  counts_readout_if tx1 ();

  counts_readout #(.NCHAN(6), .NBITS(4), .PERIOD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .counts(counts0), .start(start0),
    .snap_clear(snap0), .busy(busy0), .tx(tx0));

  counts_readout #(.NCHAN(6), .NBITS(4), .PERIOD(40)) dut1 (
    .clk(clk), .rst_n(rst_n), .counts(counts1), .start(start1),
    .snap_clear(snap1), .busy(busy1), .tx(tx1));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int sc0_n = 0;
  int busy0_n = 0;
  int sc1[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_q[$];
  int cvals[NP];
  int s0 = 0;

  // Transfers are recorded at the negedge before the edge that completes them.
  always @(negedge clk) begin
    cyc++;
    if (tx0.tx_valid && tx0.tx_ready) q0.push_back(tx0.tx_data);
    if (snap0) sc0_n++;
    if (busy0) busy0_n++;
    if (tx1.tx_valid && tx1.tx_ready) q1.push_back(tx1.tx_data);
    if (snap1) sc1.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic build_frame(input logic [7:0] s);
    logic [7:0] x;
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    x = 8'hA5 ^ s;
    for (int i = 0; i < NP; i++) begin
      exp_q.push_back(8'(cvals[i]));
      x = x ^ 8'(cvals[i]);
    end
    exp_q.push_back(x);
  endtask

  task automatic cmp_frame(input string tag);
    logic [31:0] obs;
    check({tag, "_len"}, q0.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < q0.size()) ? {24'd0, q0[i]} : 32'hdead;
      check($sformatf("%s_b%0d", tag, i), obs, {24'd0, exp_q[i]});
    end
  endtask

  function automatic logic [31:0] q1_at(input int i);
    return (i < q1.size()) ? {24'd0, q1[i]} : 32'hdead;
  endfunction

  task automatic set_counts0();
    for (int i = 0; i < NP; i++) counts0[i] = 4'(cvals[i]);
  endtask

  task automatic clear0();
    q0.delete();
    exp_q.delete();
    sc0_n = 0;
    busy0_n = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask

  task automatic wait_idle0(input string tag);
    int n;
    n = 0;
    while (busy0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, busy0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tx0.tx_ready = 1'b1;
    tx1.tx_ready = 1'b1;
    for (int i = 0; i < NP; i++) cvals[i] = i;
    set_counts0();
    for (int i = 0; i < NP; i++) counts1[i] = 4'd3;

    repeat (3) @(negedge clk);
    check("rst_valid", tx0.tx_valid, 1'b0);
    check("rst_data", tx0.tx_data, 8'h00);
    check("rst_snap", snap0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic frame, sink always ready
    clear0(); build_frame(8'(s0)); s0++;
    pulse_start();
    check("t1_lat_valid", tx0.tx_valid, 1'b1);
    check("t1_lat_data", tx0.tx_data, 8'hA5);
    check("t1_lat_snap", snap0, 1'b1);
    check("t1_lat_busy", busy0, 1'b1);
    wait_idle0("t1");
    cmp_frame("t1");
    check("t1_csum_aa", q0.size() > 17 ? q0[17] : 8'h00, 8'hAA);
    check("t1_snap_n", sc0_n, 1);
    check("t1_busy_n", busy0_n, 18);

    // Sink stalls for three cycles on byte 0x02
    clear0(); build_frame(8'(s0)); s0++;
    pulse_start();
    repeat (4) @(posedge clk);
    #1 tx0.tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t2_hold_data", tx0.tx_data, 8'h02);
      check("t2_hold_valid", tx0.tx_valid, 1'b1);
      @(posedge clk);
    end
    #1 tx0.tx_ready = 1'b1;
    wait_idle0("t2");
    cmp_frame("t2");
    check("t2_busy_n", busy0_n, 21);

    // Counts change right after the snapshot edge
    clear0(); build_frame(8'(s0)); s0++;
    pulse_start();
    for (int i = 0; i < NP; i++) counts0[i] = 4'hF;
    wait_idle0("t3");
    cmp_frame("t3");
    set_counts0();

    // Two starts during a frame give exactly one back-to-back frame
    clear0(); build_frame(8'(s0)); build_frame(8'(s0 + 1)); s0 += 2;
    pulse_start();
    repeat (2) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    wait_idle0("t4");
    cmp_frame("t4");
    check("t4_snap_n", sc0_n, 2);
    check("t4_busy_n", busy0_n, 36);
    repeat (30) @(negedge clk);
    check("t4_no_third", q0.size(), 36);

    // Start on the edge that accepts the checksum: one idle cycle, then a new frame
    clear0(); build_frame(8'(s0)); build_frame(8'(s0 + 1)); s0 += 2;
    pulse_start();
    repeat (17) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    check("t7_gap_valid", tx0.tx_valid, 1'b0);
    check("t7_gap_busy", busy0, 1'b0);
    @(posedge clk); #1;
    check("t7_relaunch_valid", tx0.tx_valid, 1'b1);
    check("t7_relaunch_data", tx0.tx_data, 8'hA5);
    check("t7_relaunch_snap", snap0, 1'b1);
    wait_idle0("t7");
    cmp_frame("t7");
    check("t7_snap_n", sc0_n, 2);
    check("t7_busy_n", busy0_n, 36);

    // Async reset in the middle of DATA aborts the frame
    clear0();
    pulse_start();
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_abort_valid", tx0.tx_valid, 1'b0);
    check("t5_abort_busy", busy0, 1'b0);
    check("t5_abort_data", tx0.tx_data, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    q1.delete();
    sc1.delete();
    s0 = 0;
    clear0(); build_frame(8'(s0)); s0++;
    pulse_start();
    wait_idle0("t5");
    cmp_frame("t5");

    // Period timer on the second instance, start tied low
    n = 0;
    while (sc1.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_three_frames", sc1.size() >= 3, 1'b1);
    repeat (5) @(negedge clk);
    if (sc1.size() >= 3) begin
      check("t6_gap1", sc1[1] - sc1[0], 40);
      check("t6_gap2", sc1[2] - sc1[1], 40);
    end
    check("t6_hdr0", q1_at(0), 32'hA5);
    check("t6_seq0", q1_at(1), 32'h00);
    check("t6_csum0", q1_at(17), 32'hA6);
    check("t6_hdr1", q1_at(18), 32'hA5);
    check("t6_seq1", q1_at(19), 32'h01);
    check("t6_seq2", q1_at(37), 32'h02);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/counts_readout.md
Name: counts_readout

Overview:
- Reader side of the pair-coincidence counter array.
- Snapshots all pair Counts of the detector on a trigger, and pulses a clear back to the detector in the same cycle.
- Serializes the snapshot as a framed byte stream over a valid/ready interface toward the host link: header, sequence number, one byte per pair, XOR checksum.
- Trigger is an explicit Start pulse or an internal period timer.

Parameters:
- NCHAN, 6, number of input channels.
- NBITS, 4, width of each pair count; legal range 1..8.
- NPAIRS, NCHAN*(NCHAN-1)/2, number of pair counts (derived, not overridden).
- PERIOD, 0, cycles between automatic triggers; 0 disables the timer.

Ports:
- Clk  input  1  clock, all logic on rising edge.
- Rst_n  input  1  reset; one clock, asynchronous and active-low.
- Counts  input  [NBITS-1:0] x [NPAIRS-1:0]  live pair counts from the detector.
- Start  input  1  trigger request, sampled each rising edge.
- Snap_clear  output  1  one-cycle pulse; detector clears its counters.
- Tx_data  output  8  stream byte.
- Tx_valid  output  1  Tx_data valid.
- Tx_ready  input  1  sink accepts byte.
- Busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - Tx_valid=0, Tx_data=0, Snap_clear=0, Busy=0.
  - State=IDLE; seq=0, timer=0, pending=0, checksum=0.
  - Reset mid-frame aborts the frame immediately. No resume; the next frame uses seq=0.
- Trigger:
  - Trigger = Start OR timer expiry OR pending.
  - A trigger is acted on only at an edge where state=IDLE.
  - At that edge: snapshot all Counts into internal registers and move to HDR.
  - Snap_clear is high for exactly the following cycle.
- Latency: Start sampled high at edge k in IDLE -> Tx_valid=1 with Tx_data=0xA5 from edge k through acceptance.
- Pending:
  - Start or timer expiry while not IDLE sets pending; there is one pending slot only.
  - Extra triggers while pending is set are dropped.
  - Pending clears when it launches a frame.
- Timer:
  - Used only when PERIOD>0.
  - Free-running 0..PERIOD-1; expires when it equals PERIOD-1, then wraps to 0.
  - Runs regardless of state.
- FSM: IDLE -> HDR -> SEQ -> DATA -> CSUM -> IDLE.
  - HDR: byte 0xA5.
  - SEQ: byte = seq.
  - DATA: NPAIRS bytes, pair 0 first. Each byte is the snapshot count zero-extended to 8 bits.
  - CSUM: byte = XOR of all preceding bytes of the frame, header included.
  - Frame length is NPAIRS+3 bytes.
- Handshake:
  - A byte transfers at an edge with Tx_valid=1 and Tx_ready=1.
  - While Tx_valid=1 and Tx_ready=0, Tx_data is held stable and Tx_valid stays high.
  - Tx_valid never drops mid-frame except on reset.
  - After a transfer, the next byte is presented in the next cycle; there is no bubble inside a frame.
- After CSUM is accepted:
  - seq increments (8-bit wrap, 255->0).
  - If pending=1, go directly to HDR with a new snapshot and Snap_clear pulse at the same edge, so the frames are back to back.
  - Otherwise go to IDLE with Tx_valid=0.
- Snapshot isolation: Counts changes after the snapshot edge never affect the frame in flight.
- Simultaneous events:
  - Start in the same cycle as timer expiry yields one trigger.
  - Start at the edge CSUM is accepted with pending=0 is captured as pending and launches at the next IDLE cycle.

Test Plan:
- NCHAN=6, NBITS=4, Counts[i]=i, Tx_ready=1, Start pulse -> 18 bytes on consecutive cycles: A5,00,00,01,...,0E, then checksum AA. One Snap_clear pulse; Busy high for 18 cycles.
- Same stimulus, Tx_ready low for 3 cycles while byte 5 (0x02) is presented -> Tx_data stays 0x02 and Tx_valid stays 1 throughout; frame otherwise identical.
- Counts all set to 0xF after the Start edge -> the frame still carries 00..0E and checksum AA.
- Two Start pulses during a frame -> exactly one further frame, back to back, with seq byte 01; no third frame.
- PERIOD=40, Start tied low, Tx_ready=1 -> frames begin every 40 cycles with seq 00,01,02; one Snap_clear per frame.
- Rst_n pulled low during the DATA state -> Tx_valid and Busy go 0 immediately (asynchronously). After release, Start gives a frame with seq 00.
